// File: rtl/ram_fifo_ctrl.sv
// Circular-buffer FIFO controller in front of a 1024x8 synchronous RAM; the RAM holds the data.
// Latency: push accepted at edge N -> RAM write in cycle N+1; pop accepted at edge N -> pop_valid in cycle N+3.
// Backpressure: one RAM op in flight; push_ready/pop_ready only in IDLE for the granted side, never on full/empty.
//
// Ports: clk/rst (sync, active high); push/push_data/push_ready; pop/pop_ready/pop_data/pop_valid;
//        count/full/empty status; err sticky protocol error; ram_addr/ram_din/ram_wr/ram_rd/ram_dout to the RAM.
// Optional feature: define RAMFIFO_ERR_EN to build the sticky error detector (otherwise err is tied to 0).
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_CAP  = 2'd3;

  // Pointers wrap at DEPTH, which need not be a power of two.
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_rr;

  logic w_full;
  logic w_empty;
  logic w_push_elig;
  logic w_pop_elig;
  logic w_grant_push;
  logic w_grant_pop;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  assign w_push_elig = (r_state == S_IDLE) && push && !w_full;
  assign w_pop_elig  = (r_state == S_IDLE) && pop && !w_empty;

  // Round-robin only matters when both sides are eligible: rr=0 favours push.
  assign w_grant_push = w_push_elig && (!w_pop_elig || !r_rr);
  assign w_grant_pop  = w_pop_elig && (!w_push_elig || r_rr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_rr        <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ram_addr/ram_din are registers so they hold their value while idle.
          if (w_grant_push) begin
            r_din   <= push_data;
            r_addr  <= r_wr_ptr;
            r_state <= S_WR;
          end else if (w_grant_pop) begin
            r_addr  <= r_rd_ptr;
            r_state <= S_RD;
          end
          if (w_push_elig && w_pop_elig) begin
            r_rr <= ~r_rr;
          end
        end
        S_WR: begin
          r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
          r_count  <= r_count + 1'b1;
          r_state  <= S_IDLE;
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          // RAM output is registered on the RD edge, so it is stable here.
          r_pop_data  <= ram_dout;
          r_pop_valid <= 1'b1;
          r_rd_ptr    <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
          r_count     <= r_count - 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAMFIFO_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && ((push && w_full) || (pop && w_empty))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign push_ready = w_grant_push;
  assign pop_ready  = w_grant_pop;
  assign pop_data   = r_pop_data;
  assign pop_valid  = r_pop_valid;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign ram_addr   = r_addr;
  assign ram_din    = r_din;
  assign ram_wr     = (r_state == S_WR);
  assign ram_rd     = (r_state == S_RD) || (r_state == S_CAP);

endmodule
